// File: rtl/uart_rx_fifo.sv
// Oversampled (16x) UART receiver feeding a show-ahead byte FIFO.
// Start-bit validation, framing-error and overrun detection with sticky flags.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          xclk,
  input  logic          rst,
  input  logic [11:0]   div,
  input  logic          RX,
  input  logic          rd,
  input  logic          clr_err,
  output logic [7:0]    dout,
  output logic          has_byte,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overrun,
  output logic          frame_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic rxSync1_q, rxSync2_q, rxs;

  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
    end else begin
      rxSync1_q <= RX;
      rxSync2_q <= rxSync1_q;
    end
  end

  assign rxs = rxSync2_q;

  // The divisor is captured in the cycle after each wrap and held until the next one.
  logic [11:0] tcnt_q, tcnt_d, divHold_q, effDiv;
  logic        tick;

  always_comb begin
    effDiv = (tcnt_q == 12'd0) ? div : divHold_q;
    tick   = (tcnt_q == effDiv);
    tcnt_d = tick ? 12'd0 : tcnt_q + 12'd1;
  end

  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      tcnt_q    <= 12'd0;
      divHold_q <= 12'd0;
    end else begin
      tcnt_q    <= tcnt_d;
      divHold_q <= effDiv;
    end
  end

  logic [1:0] state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [1:0] smp_q, smp_d;
  logic [7:0] sh_q, sh_d;
  logic       armed_q, armed_d;
  logic       maj, push, ferrSet;

  assign maj = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs) | (smp_q[0] & rxs);

  // DATA and STOP sample at scnt 13..15 so each decision lands 16 ticks after the last.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bitIdx_d = bitIdx_q;
    smp_d    = smp_q;
    sh_d     = sh_q;
    armed_d  = armed_q;
    push     = 1'b0;
    ferrSet  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = START;
          scnt_d  = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd7 || scnt_q == 4'd8) smp_d = {smp_q[0], rxs};
          if (scnt_q == 4'd9) begin
            scnt_d = 4'd0;
            if (!maj) begin
              state_d  = DATA;
              bitIdx_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd13 || scnt_q == 4'd14) smp_d = {smp_q[0], rxs};
          if (scnt_q == 4'd15) begin
            sh_d = {maj, sh_q[7:1]};
            if (bitIdx_q == 3'd7) begin
              state_d = STOP;
              scnt_d  = 4'd0;
            end else begin
              bitIdx_d = bitIdx_q + 3'd1;
            end
          end
        end
      end
      default: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd13 || scnt_q == 4'd14) smp_d = {smp_q[0], rxs};
          if (scnt_q == 4'd15) begin
            push    = maj;
            ferrSet = ~maj;
            state_d = IDLE;
            scnt_d  = 4'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      scnt_q   <= 4'd0;
      bitIdx_q <= 3'd0;
      smp_q    <= 2'b00;
      sh_q     <= 8'h00;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bitIdx_q <= bitIdx_d;
      smp_q    <= smp_d;
      sh_q     <= sh_d;
      armed_q  <= armed_d;
    end
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          isEmpty, isFull, pop, doPush, ovrSet;
  logic          overrun_q, overrun_d, frameErr_q, frameErr_d;

  // Pop is resolved before push, so a simultaneous rd always makes room.
  always_comb begin
    isEmpty = (count_q == '0);
    isFull  = (count_q == CW'(DEPTH));
    pop     = rd & ~isEmpty;
    doPush  = push & (~isFull | pop);
    ovrSet  = push & isFull & ~pop;
    count_d = count_q;
    if (doPush && !pop) count_d = count_q + CW'(1);
    else if (pop && !doPush) count_d = count_q - CW'(1);
    overrun_d  = ovrSet | (overrun_q & ~clr_err);
    frameErr_d = ferrSet | (frameErr_q & ~clr_err);
  end

  always_ff @(posedge xclk) begin
    if (doPush) mem_q[wrPtr_q] <= sh_q;
  end

  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop) rdPtr_q <= rdPtr_q + AW'(1);
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign dout      = isEmpty ? 8'h00 : mem_q[rdPtr_q];
  assign has_byte  = ~isEmpty;
  assign full      = isFull;
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a tick-indexed frame model plus a queue
// predicts every output each cycle, and directed scenarios pin literal values.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int BITCLK = 64;

  logic        xclk;
  logic        rst;
  logic [11:0] div;
  logic        RX;
  logic        rd;
  logic        clr_err;
  logic [7:0]  dout;
  logic        has_byte;
  logic        full;
  logic [3:0]  count;
  logic        overrun;
  logic        frame_err;

  int checkCount = 0;
  int errCount = 0;
  bit compareEn = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .CW(4)) dut (
    .xclk(xclk), .rst(rst), .div(div), .RX(RX), .rd(rd), .clr_err(clr_err),
    .dout(dout), .has_byte(has_byte), .full(full), .count(count),
    .overrun(overrun), .frame_err(frame_err)
  );

  initial begin
    xclk = 0;
    forever #5 xclk = ~xclk;
  end

  // Model: ticks are numbered from the start edge; data bit b is decided at
  // tick 26+16b from samples 24+16b..26+16b, the stop bit at tick 154.
  logic [7:0] mQ[$];
  logic       mOvr, mFe, mBusy, mArmed;
  logic [1:0] mSync;
  int         mCyc, mTicks;
  logic       mSamp [0:159];

  function automatic logic maj3(int n);
    int ones;
    ones = int'(mSamp[n]) + int'(mSamp[n+1]) + int'(mSamp[n+2]);
    return ones >= 2;
  endfunction

  always @(posedge xclk or posedge rst) begin
    logic rxsM, tickM, pushM, feSetM, ovrSetM;
    logic [7:0] byteM;
    if (rst) begin
      mQ.delete();
      mOvr = 0; mFe = 0; mSync = 2'b11; mCyc = 0;
      mBusy = 0; mArmed = 0; mTicks = 0;
    end else begin
      rxsM = mSync[1];
      tickM = (mCyc % (int'(div) + 1)) == int'(div);
      pushM = 0; feSetM = 0; ovrSetM = 0; byteM = 8'h00;
      if (!mBusy) begin
        if (rxsM) mArmed = 1;
        else if (mArmed) begin
          mBusy = 1; mArmed = 0; mTicks = 0;
        end
      end else if (tickM) begin
        mTicks++;
        mSamp[mTicks] = rxsM;
        if (mTicks == 10 && maj3(8)) mBusy = 0;
        else if (mTicks == 154) begin
          mBusy = 0;
          for (int b = 0; b < 8; b++) byteM[b] = maj3(24 + 16 * b);
          if (maj3(152)) pushM = 1;
          else feSetM = 1;
        end
      end
      if (rd && mQ.size() > 0) void'(mQ.pop_front());
      if (pushM) begin
        if (mQ.size() < DEPTH) mQ.push_back(byteM);
        else ovrSetM = 1;
      end
      if (clr_err) begin mOvr = 0; mFe = 0; end
      if (ovrSetM) mOvr = 1;
      if (feSetM) mFe = 1;
      mSync = {mSync[0], RX};
      mCyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge xclk) begin
    if (compareEn) begin
      checkOutput("cyc_count", 32'(count), 32'(mQ.size()));
      checkOutput("cyc_has_byte", 32'(has_byte), 32'(mQ.size() > 0));
      checkOutput("cyc_full", 32'(full), 32'(mQ.size() == DEPTH));
      checkOutput("cyc_dout", 32'(dout), 32'(mQ.size() > 0 ? mQ[0] : 8'h00));
      checkOutput("cyc_overrun", 32'(overrun), 32'(mOvr));
      checkOutput("cyc_frame_err", 32'(frame_err), 32'(mFe));
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    RX = 0;
    repeat (BITCLK) @(negedge xclk);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (BITCLK) @(negedge xclk);
    end
    RX = stopBit;
    repeat (BITCLK) @(negedge xclk);
  endtask

  task automatic popByte(input logic [7:0] expected, input string name);
    checkOutput(name, 32'(dout), 32'(expected));
    rd = 1;
    @(negedge xclk);
    rd = 0;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_dout"}, 32'(dout), 0);
    checkOutput({name, "_has"}, 32'(has_byte), 0);
    checkOutput({name, "_full"}, 32'(full), 0);
    checkOutput({name, "_count"}, 32'(count), 0);
    checkOutput({name, "_ovr"}, 32'(overrun), 0);
    checkOutput({name, "_fe"}, 32'(frame_err), 0);
  endtask

  initial begin
    bit hit;
    rst = 1; RX = 1; rd = 0; clr_err = 0; div = 12'd3;
    repeat (3) @(negedge xclk);
    compareEn = 1;
    checkAllZero("reset");
    #2 rst = 0;
    repeat (20) @(negedge xclk);

    $display("[TB] scenario 1: byte A5");
    applyStimulus(8'hA5, 1);
    repeat (20) @(negedge xclk);
    checkOutput("t1_has", 32'(has_byte), 1);
    checkOutput("t1_count", 32'(count), 1);
    checkOutput("t1_model_count", 32'(mQ.size()), 1);
    checkOutput("t1_ovr", 32'(overrun), 0);
    checkOutput("t1_fe", 32'(frame_err), 0);
    popByte(8'hA5, "t1_dout");
    checkOutput("t1_empty_has", 32'(has_byte), 0);
    checkOutput("t1_empty_dout", 32'(dout), 0);

    $display("[TB] scenario 2: glitch then 3C");
    RX = 0;
    repeat (20) @(negedge xclk);
    RX = 1;
    repeat (300) @(negedge xclk);
    checkOutput("t2_glitch_count", 32'(count), 0);
    checkOutput("t2_glitch_fe", 32'(frame_err), 0);
    applyStimulus(8'h3C, 1);
    repeat (20) @(negedge xclk);
    checkOutput("t2_count", 32'(count), 1);
    popByte(8'h3C, "t2_dout");

    $display("[TB] scenario 3: framing error and break");
    applyStimulus(8'h55, 0);
    repeat (300) @(negedge xclk);
    checkOutput("t3_fe", 32'(frame_err), 1);
    checkOutput("t3_model_fe", 32'(mFe), 1);
    checkOutput("t3_count", 32'(count), 0);
    RX = 1;
    repeat (100) @(negedge xclk);
    applyStimulus(8'h01, 1);
    repeat (20) @(negedge xclk);
    checkOutput("t3_count1", 32'(count), 1);
    checkOutput("t3_fe_sticky", 32'(frame_err), 1);
    clr_err = 1;
    @(negedge xclk);
    clr_err = 0;
    checkOutput("t3_fe_clr", 32'(frame_err), 0);
    popByte(8'h01, "t3_dout");

    $display("[TB] scenario 4: overrun");
    for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1);
    repeat (20) @(negedge xclk);
    checkOutput("t4_count", 32'(count), 8);
    checkOutput("t4_full", 32'(full), 1);
    checkOutput("t4_ovr", 32'(overrun), 1);
    checkOutput("t4_model_ovr", 32'(mOvr), 1);
    for (int i = 0; i < 8; i++) popByte(8'(i), "t4_dout");
    checkOutput("t4_has", 32'(has_byte), 0);

    $display("[TB] scenario 5: rd in the push cycle while full");
    clr_err = 1;
    @(negedge xclk);
    clr_err = 0;
    checkOutput("t5_ovr_clr", 32'(overrun), 0);
    for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1);
    hit = 0;
    fork
      applyStimulus(8'hEE, 1);
      begin
        for (int k = 0; k < 2000 && !hit; k++) begin
          @(negedge xclk);
          if (mBusy && mTicks == 153 && (mCyc % (int'(div) + 1)) == int'(div)) begin
            rd = 1;
            @(negedge xclk);
            rd = 0;
            hit = 1;
          end
        end
      end
    join
    checkOutput("t5_push_found", 32'(hit), 1);
    repeat (20) @(negedge xclk);
    checkOutput("t5_ovr", 32'(overrun), 0);
    checkOutput("t5_count", 32'(count), 8);
    for (int i = 1; i < 8; i++) popByte(8'h10 + 8'(i), "t5_dout");
    popByte(8'hEE, "t5_last");
    checkOutput("t5_has", 32'(has_byte), 0);

    $display("[TB] scenario 6: reset mid-frame");
    applyStimulus(8'h42, 1);
    repeat (20) @(negedge xclk);
    checkOutput("t6_pre_count", 32'(count), 1);
    RX = 0;
    repeat (BITCLK) @(negedge xclk);
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (BITCLK) @(negedge xclk);
    end
    RX = 0;
    repeat (32) @(negedge xclk);
    #2 rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge xclk);
      checkAllZero("t6_rst");
    end
    #2 rst = 0;
    RX = 1;
    repeat (200) @(negedge xclk);
    applyStimulus(8'h81, 1);
    repeat (20) @(negedge xclk);
    checkOutput("t6_count", 32'(count), 1);
    checkOutput("t6_fe", 32'(frame_err), 0);
    popByte(8'h81, "t6_dout");
    checkOutput("t6_has", 32'(has_byte), 0);

    compareEn = 0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
